// File: rtl/bipolar_sng_pair.sv
// Dual-channel bipolar stochastic number generator: two 8-bit offset-binary codes
// become two 255-bit frames whose ones count equals the code, from one shared LFSR.
module bipolar_sng_pair #(
    parameter logic [7:0] SEED      = 8'h01,
    parameter bit         REVERSE_B = 1'b1
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iLoad,
    input  logic [7:0] iValA,
    input  logic [7:0] iValB,
    input  logic       iCont,
    input  logic       iEn,
    output logic       oReady,
    output logic       oA,
    output logic       oB,
    output logic       oValid,
    output logic       oFrameStart,
    output logic       oFrameLast
);

    localparam int unsigned W = 8;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;
    localparam logic [W-1:0] LAST_CNT = W'(254);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
    logic [W-1:0] lfsr_q, lfsr_d, cnt_q, cnt_d;
    logic [W-1:0] lfsr_next, lfsr_rev, rnd_a, rnd_b;
    logic         ready_d, a_d, b_d, valid_d, fs_d, fl_d;

    // x^8+x^6+x^5+x^4+1 Fibonacci step and the per-channel random values
    always_comb begin
        lfsr_next = {lfsr_q[W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lfsr_rev  = '0;
        for (int i = 0; i < int'(W); i++) begin
            lfsr_rev[i] = lfsr_q[W-1-i];
        end
        rnd_a = lfsr_q;
        rnd_b = REVERSE_B ? lfsr_rev : lfsr_q;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        a_d     = oA;
        b_d     = oB;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        fl_d    = 1'b0;

        case (state_q)
            IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (iLoad) begin
                    val_a_d = iValA;
                    val_b_d = iValB;
                    lfsr_d  = SEED_EFF;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (iEn) begin
                    a_d     = (rnd_a <= val_a_q);
                    b_d     = (rnd_b <= val_b_q);
                    valid_d = 1'b1;
                    fs_d    = (cnt_q == '0);
                    fl_d    = (cnt_q == LAST_CNT);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d  = '0;
                        lfsr_d = SEED_EFF;
                        if (!iCont) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d  = cnt_q + W'(1);
                        lfsr_d = lfsr_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= IDLE;
            val_a_q     <= '0;
            val_b_q     <= '0;
            lfsr_q      <= SEED_EFF;
            cnt_q       <= '0;
            oReady      <= 1'b1;
            oA          <= 1'b0;
            oB          <= 1'b0;
            oValid      <= 1'b0;
            oFrameStart <= 1'b0;
            oFrameLast  <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_a_q     <= val_a_d;
            val_b_q     <= val_b_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            oReady      <= ready_d;
            oA          <= a_d;
            oB          <= b_d;
            oValid      <= valid_d;
            oFrameStart <= fs_d;
            oFrameLast  <= fl_d;
        end
    end

endmodule

// File: tb/tb_bipolar_sng_pair.sv
// Bench for bipolar_sng_pair: a reversed-B instance and a correlated (seed 0) instance
// share stimulus; expected bits are queued per frame and checked as oValid bits arrive.
module tb_bipolar_sng_pair;

    logic       iClk = 1'b0;
    logic       iRstN, iLoad, iCont, iEn;
    logic [7:0] iValA, iValB;
    logic       oReady, oA, oB, oValid, oFrameStart, oFrameLast;
    logic       oReady_c, oA_c, oB_c, oValid_c, oFrameStart_c, oFrameLast_c;

    always #5 iClk = ~iClk;

    bipolar_sng_pair #(.SEED(8'h01), .REVERSE_B(1'b1)) dut (
        .iClk(iClk), .iRstN(iRstN), .iLoad(iLoad), .iValA(iValA), .iValB(iValB),
        .iCont(iCont), .iEn(iEn), .oReady(oReady), .oA(oA), .oB(oB), .oValid(oValid),
        .oFrameStart(oFrameStart), .oFrameLast(oFrameLast)
    );

    bipolar_sng_pair #(.SEED(8'h00), .REVERSE_B(1'b0)) dut_c (
        .iClk(iClk), .iRstN(iRstN), .iLoad(iLoad), .iValA(iValA), .iValB(iValB),
        .iCont(iCont), .iEn(iEn), .oReady(oReady_c), .oA(oA_c), .oB(oB_c), .oValid(oValid_c),
        .oFrameStart(oFrameStart_c), .oFrameLast(oFrameLast_c)
    );

    typedef struct packed {
        logic a;
        logic b;
        logic bc;
        logic fs;
        logic fl;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int n_valid, n_a, n_b, n_ab, n_diff, n_bc, n_cc_neq;
    bit in_frame, chk_hold, saw_fl;
    logic prev_a, prev_b;
    logic [254:0] seq, seq1;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] l);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = l[7-i];
        return r;
    endfunction

    // Reference frame: effective seed is 1 for both instances
    task automatic push_frame(input logic [7:0] va, input logic [7:0] vb);
        logic [7:0] l;
        exp_t e;
        l = 8'h01;
        for (int i = 0; i < 255; i++) begin
            e.a  = (l <= va);
            e.b  = (rev8(l) <= vb);
            e.bc = (l <= vb);
            e.fs = (i == 0);
            e.fl = (i == 254);
            exp_q.push_back(e);
            l = lfsr_step(l);
        end
    endtask

    task automatic reset_counts();
        n_valid = 0; n_a = 0; n_b = 0; n_ab = 0; n_diff = 0; n_bc = 0; n_cc_neq = 0;
        saw_fl = 1'b0;
        seq = '0;
    endtask

    // One clock: sample on the falling edge, score any valid bit
    task automatic cyc();
        exp_t e;
        @(negedge iClk);
        if (oValid) begin
            if (exp_q.size() == 0) begin
                chkn("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk1("bit_a", oA, e.a);
                chk1("bit_b", oB, e.b);
                chk1("bit_a_corr", oA_c, e.a);
                chk1("bit_b_corr", oB_c, e.bc);
                chk1("valid_corr", oValid_c, 1'b1);
                chk1("frame_start", oFrameStart, e.fs);
                chk1("frame_last", oFrameLast, e.fl);
            end
            if (n_valid < 255) seq[n_valid] = oA;
            n_valid++;
            n_a      += int'(oA);
            n_b      += int'(oB);
            n_ab     += int'(oA & oB);
            n_diff   += int'(oA != oB);
            n_bc     += int'(oB_c);
            n_cc_neq += int'(oA_c != oB_c);
            in_frame = !oFrameLast;
            saw_fl   = saw_fl | oFrameLast;
        end else if (chk_hold && in_frame) begin
            chk1("hold_a", oA, prev_a);
            chk1("hold_b", oB, prev_b);
            chk1("stall_fs", oFrameStart, 1'b0);
            chk1("stall_fl", oFrameLast, 1'b0);
        end
        prev_a = oA;
        prev_b = oB;
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_ready"}, oReady, 1'b1);
        chk1({tag, "_a"}, oA, 1'b0);
        chk1({tag, "_b"}, oB, 1'b0);
        chk1({tag, "_valid"}, oValid, 1'b0);
        chk1({tag, "_fs"}, oFrameStart, 1'b0);
        chk1({tag, "_fl"}, oFrameLast, 1'b0);
        chk1({tag, "_ready_c"}, oReady_c, 1'b1);
        chk1({tag, "_valid_c"}, oValid_c, 1'b0);
    endtask

    // Accept a load and check the two-cycle first-bit latency
    task automatic load(input logic [7:0] va, input logic [7:0] vb);
        iValA = va; iValB = vb; iLoad = 1'b1; iEn = 1'b1;
        reset_counts();
        push_frame(va, vb);
        cyc();
        iLoad = 1'b0;
        chk1("load_ready_low", oReady, 1'b0);
        chk1("load_no_bit_yet", oValid, 1'b0);
        cyc();
        chk1("first_bit_valid", oValid, 1'b1);
        chk1("first_bit_start", oFrameStart, 1'b1);
    endtask

    task automatic run_frame(input int budget, input bit rnd_en, input logic exp_ready);
        int n;
        n = 0;
        while (!saw_fl && n < budget) begin
            if (rnd_en) iEn = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        iEn = 1'b1;
        chk1("frame_end_seen", saw_fl, 1'b1);
        chk1("ready_at_last", oReady, exp_ready);
        chkn("valid_bits", n_valid, 255);
    endtask

    initial begin
        int guard;
        iRstN = 1'b0; iLoad = 1'b0; iCont = 1'b0; iEn = 1'b1;
        iValA = 8'd0; iValB = 8'd0; chk_hold = 1'b0; in_frame = 1'b0;
        prev_a = 1'b0; prev_b = 1'b0;
        reset_counts();
        repeat (3) @(negedge iClk);
        check_idle("reset");
        iRstN = 1'b1;
        cyc();
        check_idle("idle");

        // Full-scale A, zero B
        load(8'd255, 8'd0);
        run_frame(300, 1'b0, 1'b1);
        chkn("t1_ones_a", n_a, 255);
        chkn("t1_ones_b", n_b, 0);
        cyc();
        check_idle("t1_after");

        // Mid-scale, decorrelated channels
        load(8'd128, 8'd64);
        run_frame(300, 1'b0, 1'b1);
        chkn("t2_ones_a", n_a, 128);
        chkn("t2_ones_b", n_b, 64);
        chkn("t2_ones_b_corr", n_bc, 64);
        chk1("t2_streams_differ", n_diff > 0, 1'b1);
        chk1("t2_and_not_64", n_ab != 64, 1'b1);
        cyc();

        // Equal operands: correlated instance gives identical streams
        load(8'd100, 8'd100);
        run_frame(300, 1'b0, 1'b1);
        chkn("t3_corr_neq", n_cc_neq, 0);
        chkn("t3_ones_a", n_a, 100);
        chkn("t3_ones_b_corr", n_bc, 100);
        cyc();

        // Random stalls
        load(8'd200, 8'd55);
        chk_hold = 1'b1;
        run_frame(2000, 1'b1, 1'b1);
        chk_hold = 1'b0;
        chkn("t4_ones_a", n_a, 200);
        chkn("t4_ones_b", n_b, 55);
        cyc();

        // Continuous mode: two gapless identical frames
        iCont = 1'b1;
        load(8'd37, 8'd37);
        push_frame(8'd37, 8'd37);
        run_frame(300, 1'b0, 1'b0);
        chkn("t5_ones_a1", n_a, 37);
        seq1 = seq;
        iCont = 1'b0;
        reset_counts();
        cyc();
        chk1("t5_gapless_start", oFrameStart, 1'b1);
        run_frame(300, 1'b0, 1'b1);
        chkn("t5_ones_a2", n_a, 37);
        chk1("t5_identical", seq == seq1, 1'b1);
        chkn("t5_queue_drained", exp_q.size(), 0);
        cyc();

        // Ignored mid-frame load, then async reset at bit 100
        load(8'd150, 8'd90);
        repeat (40) cyc();
        iLoad = 1'b1; iValA = 8'd3; iValB = 8'd250;
        cyc();
        iLoad = 1'b0;
        chk1("t6_ready_in_run", oReady, 1'b0);
        guard = 0;
        while (n_valid < 100 && guard < 400) begin
            cyc();
            guard++;
        end
        chkn("t6_bits_before_reset", n_valid, 100);
        iRstN = 1'b0;
        #1;
        check_idle("t6_async_reset");
        exp_q.delete();
        cyc();
        iRstN = 1'b1;
        repeat (3) begin
            cyc();
            check_idle("t6_no_restart");
        end
        chkn("t6_no_more_bits", n_valid, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
